// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised line, mid-bit sampling, single-entry
// AXI-Stream output register with framing-error and overrun status pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rxd,
    output logic       o_m_axis_tvalid,
    input  logic       i_m_axis_tready,
    output logic [7:0] o_m_axis_tdata,
    output logic       o_rxd_busy,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    localparam logic [7:0] HALF_M1 = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] FULL_M1 = 8'(CLKS_PER_BIT - 1);

    logic [2:0] state;
    logic       rxd_meta;
    logic       rxd_s;
    logic [7:0] cnt;
    logic [2:0] idx;
    logic [7:0] sh;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= S_IDLE;
            rxd_meta        <= 1'b1;
            rxd_s           <= 1'b1;
            cnt             <= '0;
            idx             <= '0;
            sh              <= '0;
            o_m_axis_tvalid <= 1'b0;
            o_m_axis_tdata  <= '0;
            o_rxd_busy      <= 1'b0;
            o_frame_err     <= 1'b0;
            o_overrun       <= 1'b0;
        end else begin
            rxd_meta    <= i_rxd;
            rxd_s       <= rxd_meta;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;

            // A delivery in STOP below overrides this clear on the same edge.
            if (o_m_axis_tvalid && i_m_axis_tready) begin
                o_m_axis_tvalid <= 1'b0;
            end

            // o_rxd_busy is set alongside every transition so it mirrors state != IDLE.
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rxd_s) begin
                        state      <= S_START;
                        o_rxd_busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rxd_s) begin
                            state <= S_DATA;
                        end else begin
                            state      <= S_IDLE;
                            o_rxd_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_M1) begin
                        sh  <= {rxd_s, sh[7:1]};
                        cnt <= '0;
                        if (idx == 3'd7) begin
                            state <= S_STOP;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            state      <= S_IDLE;
                            o_rxd_busy <= 1'b0;
                            if (!o_m_axis_tvalid || i_m_axis_tready) begin
                                o_m_axis_tdata  <= sh;
                                o_m_axis_tvalid <= 1'b1;
                            end else begin
                                o_overrun <= 1'b1;
                            end
                        end else begin
                            state       <= S_BREAK;
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_BREAK: begin
                    cnt <= '0;
                    if (rxd_s) begin
                        state      <= S_IDLE;
                        o_rxd_busy <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    o_rxd_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, hand-written corner sequences
// and randomized traffic checked against an in-order byte queue model.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_rxd;
    logic       tready;
    logic       tvalid;
    logic [7:0] tdata;
    logic       busy;
    logic       ferr;
    logic       ovr;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_rxd          (i_rxd),
        .o_m_axis_tvalid(tvalid),
        .i_m_axis_tready(tready),
        .o_m_axis_tdata (tdata),
        .o_rxd_busy     (busy),
        .o_frame_err    (ferr),
        .o_overrun      (ovr)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ferr  = 0;
    int n_ovr   = 0;
    logic [7:0] rxq[$];
    logic       rnd_en = 1'b0;

    // Transfers are recorded at the negedge, i.e. on the cycle before the edge that completes them.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (tvalid && tready) rxq.push_back(tdata);
            if (ferr) n_ferr++;
            if (ovr) n_ovr++;
        end
    end

    always @(posedge i_clk) begin
        if (rnd_en) begin
            #2;
            tready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Starts just after an edge; the next edge is E0. Returns 10 bit-times later.
    task automatic send_frame(input logic [7:0] d, input logic stopb);
        i_rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            i_rxd = d[i];
            idle(CPB);
        end
        i_rxd = stopb;
        idle(CPB);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stopb;
        logic       rdy;
        logic       pre_v;
        logic       v;
        logic [7:0] q;
        logic       fe;
        logic       ov;
        logic       v_next;
        logic       busy_next;
    } vec_t;

    vec_t tbl[5];
    logic [7:0] expq[$];
    int f0;
    int o0;
    int cnt_busy;
    int cnt_v;
    int cnt_fe;

    initial begin
        //            data   stop  rdy   pre_v v     q      fe    ov    v_next busy_next
        tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0};

        i_rst  = 1'b1;
        i_rxd  = 1'b1;
        tready = 1'b1;
        idle(3);
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", 32'(tdata), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ferr", 32'(ferr), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        i_rst = 1'b0;
        idle(5);

        for (int k = 0; k < 5; k++) begin
            tready = tbl[k].rdy;
            fork
                send_frame(tbl[k].data, tbl[k].stopb);
                begin
                    idle(154);
                    chk($sformatf("v%0d_pre_tvalid", k), 32'(tvalid), 32'(tbl[k].pre_v));
                    chk($sformatf("v%0d_pre_busy", k), 32'(busy), 32'd1);
                    idle(1);
                    chk($sformatf("v%0d_tvalid", k), 32'(tvalid), 32'(tbl[k].v));
                    chk($sformatf("v%0d_tdata", k), 32'(tdata), 32'(tbl[k].q));
                    chk($sformatf("v%0d_ferr", k), 32'(ferr), 32'(tbl[k].fe));
                    chk($sformatf("v%0d_ovr", k), 32'(ovr), 32'(tbl[k].ov));
                    idle(1);
                    chk($sformatf("v%0d_tvalid_next", k), 32'(tvalid), 32'(tbl[k].v_next));
                    chk($sformatf("v%0d_ferr_next", k), 32'(ferr), 32'd0);
                    chk($sformatf("v%0d_ovr_next", k), 32'(ovr), 32'd0);
                    chk($sformatf("v%0d_busy_next", k), 32'(busy), 32'(tbl[k].busy_next));
                end
            join
            i_rxd = 1'b1;
            idle(20);
        end

        tready = 1'b1;
        idle(5);

        // Short low glitch: START must abort without flags.
        cnt_busy = 0;
        cnt_v    = 0;
        cnt_fe   = 0;
        i_rxd    = 1'b0;
        for (int k = 0; k < 40; k++) begin
            idle(1);
            if (k == 3) i_rxd = 1'b1;
            if (busy) cnt_busy++;
            if (tvalid) cnt_v++;
            if (ferr) cnt_fe++;
        end
        chk("glitch_busy_cycles", 32'(cnt_busy), 32'd8);
        chk("glitch_tvalid", 32'(cnt_v), 32'd0);
        chk("glitch_ferr", 32'(cnt_fe), 32'd0);

        // Bad stop bit, then a long break, then a good frame.
        rxq.delete();
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        idle(20 * CPB);
        chk("break_busy", 32'(busy), 32'd1);
        idle(20 * CPB);
        i_rxd = 1'b1;
        idle(20);
        chk("break_ferr_count", 32'(n_ferr - f0), 32'd1);
        chk("break_no_byte", 32'(rxq.size()), 32'd0);
        send_frame(8'h3C, 1'b1);
        idle(20);
        chk("break_after_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) chk("break_after_byte", 32'(rxq[0]), 32'h3C);
        chk("break_ferr_final", 32'(n_ferr - f0), 32'd1);

        // Back-to-back frames into a stalled output register.
        tready = 1'b0;
        rxq.delete();
        o0 = n_ovr;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(5);
        chk("ovr_tvalid", 32'(tvalid), 32'd1);
        chk("ovr_tdata_held", 32'(tdata), 32'h11);
        chk("ovr_count", 32'(n_ovr - o0), 32'd1);
        tready = 1'b1;
        idle(1);
        chk("ovr_tvalid_after", 32'(tvalid), 32'd0);
        chk("ovr_xfer_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) chk("ovr_xfer_byte", 32'(rxq[0]), 32'h11);

        // tready rises exactly on the stop-sample edge with a byte pending.
        tready = 1'b0;
        send_frame(8'h11, 1'b1);
        idle(5);
        rxq.delete();
        o0 = n_ovr;
        fork
            send_frame(8'h22, 1'b1);
            begin
                idle(154);
                tready = 1'b1;
                idle(1);
                chk("edge_tvalid", 32'(tvalid), 32'd1);
                chk("edge_tdata", 32'(tdata), 32'h22);
                chk("edge_ovr", 32'(ovr), 32'd0);
            end
        join
        chk("edge_ovr_count", 32'(n_ovr - o0), 32'd0);
        chk("edge_xfer_count", 32'(rxq.size()), 32'd2);
        if (rxq.size() == 2) begin
            chk("edge_xfer0", 32'(rxq[0]), 32'h11);
            chk("edge_xfer1", 32'(rxq[1]), 32'h22);
        end

        // Reset mid-DATA with a byte pending: both are lost.
        tready = 1'b0;
        send_frame(8'h77, 1'b1);
        idle(5);
        chk("prerst_tvalid", 32'(tvalid), 32'd1);
        rxq.delete();
        fork
            send_frame(8'h5A, 1'b1);
            begin
                idle(60);
                i_rst = 1'b1;
                idle(100);
                i_rst = 1'b0;
            end
        join
        chk("rst_mid_tvalid", 32'(tvalid), 32'd0);
        chk("rst_mid_tdata", 32'(tdata), 32'h00);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        tready = 1'b1;
        idle(5);
        send_frame(8'hC3, 1'b1);
        idle(5);
        chk("rst_after_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) chk("rst_after_byte", 32'(rxq[0]), 32'hC3);

        // Loopback sweep 0x00..0xFF back-to-back, then random bytes/gaps/backpressure.
        rxq.delete();
        expq.delete();
        f0 = n_ferr;
        o0 = n_ovr;
        for (int b = 0; b < 256; b++) begin
            expq.push_back(8'(b));
            send_frame(8'(b), 1'b1);
        end
        rnd_en = 1'b1;
        for (int k = 0; k < 64; k++) begin
            logic [7:0] rb;
            rb = 8'($urandom);
            expq.push_back(rb);
            send_frame(rb, 1'b1);
            idle(int'($urandom_range(0, 30)));
        end
        rnd_en = 1'b0;
        idle(3);
        tready = 1'b1;
        idle(20);
        chk("stream_count", 32'(rxq.size()), 32'(expq.size()));
        for (int k = 0; k < expq.size(); k++) begin
            if (k < rxq.size()) chk($sformatf("stream_byte%0d", k), 32'(rxq[k]), 32'(expq[k]));
        end
        chk("stream_ferr", 32'(n_ferr - f0), 32'd0);
        chk("stream_ovr", 32'(n_ovr - o0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
